// File: rtl/estimador_mvmult_pkg.sv
// Shared types and defaults for the estimator matrix-vector MAC sequencer.
package estimador_mvmult_pkg;

    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 3;
    localparam int DEF_LAT  = 2;

    // Requester ids; also the bit position in req/done.
    localparam logic REQ_PRED = 1'b0;
    localparam logic REQ_CORR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

endpackage

// File: rtl/estimador_rr_arb2.sv
// Two-input round-robin arbiter. The requester granted last loses a tie.
// The pointer only moves when upd_en is high, so a grant offered while
// the sequencer is busy has no side effect.
module estimador_rr_arb2
    import estimador_mvmult_pkg::*;
(
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic       gnt_id,
    output logic       gnt_vld
);

    logic last_q;

    // Grant selection: tie goes to the requester not served last.
    always_comb begin
        gnt_vld = |req;
        if (req == 2'b11)
            gnt_id = ~last_q;
        else if (req[REQ_CORR])
            gnt_id = REQ_CORR;
        else
            gnt_id = REQ_PRED;
    end

    // Last-grant pointer; reset value makes the predictor win the first tie.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)
            last_q <= REQ_CORR;
        else if (upd_en && gnt_vld)
            last_q <= gnt_id;
    end

endmodule

// File: rtl/estimador_mvmult_sched.sv
// Sequencer for the shared MAC datapath: arbitrates between predictor and
// corrector, walks ROWS x COLS one element per cycle, waits out the
// datapath latency and strobes one result write per row. Every output is
// a register loaded from the current state, so outputs trail the state
// register by one cycle.
module estimador_mvmult_sched
    import estimador_mvmult_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int LAT   = DEF_LAT,
    parameter int IDX_W = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [1:0]       req,
    output logic             grant_id,
    output logic             busy,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic             res_we,
    output logic [IDX_W-1:0] res_row,
    output logic [1:0]       done
);

    localparam int DRN_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((LAT > 0) ? LAT - 1 : 0);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] row_q, col_q;
    logic [DRN_W-1:0] drn_q;
    logic             gnt_q;

    logic             arb_id, arb_vld, arb_upd;

    logic             busy_d, mac_en_d, mac_clr_d, res_we_d;
    logic [1:0]       done_d;

    // Arbitration result is only consumed in IDLE.
    assign arb_upd = (state_q == S_IDLE);

    estimador_rr_arb2 u_arb (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .req      (req),
        .upd_en   (arb_upd),
        .gnt_id   (arb_id),
        .gnt_vld  (arb_vld)
    );

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic. LAT=0 skips DRAIN entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (arb_vld) state_d = S_ISSUE;
            S_ISSUE: if (col_q == COL_LAST) state_d = (LAT == 0) ? S_WRITE : S_DRAIN;
            S_DRAIN: if (drn_q == DRN_LAST) state_d = S_WRITE;
            S_WRITE: state_d = (row_q == ROW_LAST) ? S_FIN : S_ISSUE;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Row/column/drain counters and the latched owner. Counters saturate at
    // their last value instead of wrapping, so indices stay inside the matrix.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            row_q <= '0;
            col_q <= '0;
            drn_q <= '0;
            gnt_q <= REQ_PRED;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arb_vld) begin
                        gnt_q <= arb_id;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                S_ISSUE: begin
                    if (col_q == COL_LAST)
                        drn_q <= '0;
                    else
                        col_q <= col_q + 1'b1;
                end
                S_DRAIN: begin
                    if (drn_q != DRN_LAST)
                        drn_q <= drn_q + 1'b1;
                end
                S_WRITE: begin
                    if (row_q != ROW_LAST) begin
                        row_q <= row_q + 1'b1;
                        col_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the current state, registered below.
    always_comb begin
        busy_d    = (state_q != S_IDLE);
        mac_en_d  = (state_q == S_ISSUE);
        mac_clr_d = (state_q == S_ISSUE) && (col_q == '0);
        res_we_d  = (state_q == S_WRITE);
        done_d    = '0;
        if (state_q == S_FIN)
            done_d[gnt_q] = 1'b1;
    end

    // Output registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            busy     <= 1'b0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            res_we   <= 1'b0;
            done     <= '0;
            grant_id <= REQ_PRED;
            row_idx  <= '0;
            col_idx  <= '0;
            res_row  <= '0;
        end else begin
            busy     <= busy_d;
            mac_en   <= mac_en_d;
            mac_clr  <= mac_clr_d;
            res_we   <= res_we_d;
            done     <= done_d;
            grant_id <= gnt_q;
            row_idx  <= row_q;
            col_idx  <= col_q;
            res_row  <= row_q;
        end
    end

endmodule

// File: tb/tb_estimador_mvmult_sched.sv
// Scoreboard bench for estimador_mvmult_sched. Two instances: defaults
// (3x3, LAT=2) and a 4x2, LAT=0 variant. A timeline model predicts, for each
// accepted request, the absolute cycle of every mac_en, res_we and done;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_estimador_mvmult_sched;

    typedef struct {
        int         cyc;
        logic       grant;
        logic [1:0] row;
        logic [1:0] col;
        logic       clr;
        logic [1:0] done;
    } evt_t;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [1:0]      req0, req1;
    logic [1:0]      gnt_o, busy_o, mac_o, clr_o, we_o;
    logic [1:0][1:0] row_o, col_o, rrow_o, done_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit var_run = 1'b0;

    evt_t mac_q[2][$];
    evt_t we_q[2][$];
    evt_t done_q[2][$];
    bit   last_g[2];
    int   next_ok[2];
    int   busy_from[2];
    int   busy_to[2];
    logic exp_g[2];
    int   n_done[2];

    always #5 ap_clk = ~ap_clk;

    estimador_mvmult_sched #(.ROWS(3), .COLS(3), .LAT(2), .IDX_W(2)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req(req0),
        .grant_id(gnt_o[0]), .busy(busy_o[0]), .mac_en(mac_o[0]), .mac_clr(clr_o[0]),
        .row_idx(row_o[0]), .col_idx(col_o[0]), .res_we(we_o[0]), .res_row(rrow_o[0]),
        .done(done_o[0])
    );

    estimador_mvmult_sched #(.ROWS(4), .COLS(2), .LAT(0), .IDX_W(2)) dut_v (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req(req1),
        .grant_id(gnt_o[1]), .busy(busy_o[1]), .mac_en(mac_o[1]), .mac_clr(clr_o[1]),
        .row_idx(row_o[1]), .col_idx(col_o[1]), .res_we(we_o[1]), .res_row(rrow_o[1]),
        .done(done_o[1])
    );

    function automatic int rows_of(input int i); return (i == 0) ? 3 : 4; endfunction
    function automatic int cols_of(input int i); return (i == 0) ? 3 : 2; endfunction
    function automatic int lat_of (input int i); return (i == 0) ? 2 : 0; endfunction

    task automatic chk(input string nm, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference timeline: a request seen while the requester side is free
    // starts a job whose first mac_en is the next cycle; row r occupies
    // COLS+LAT+1 cycles; done follows the last write; the next request can
    // be accepted two edges after the done cycle begins.
    logic [1:0] m_r;
    logic       m_g;
    int         m_p, m_base;
    evt_t       m_e;
    always @(posedge ap_clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_r = (i == 0) ? req0 : req1;
            if (!ap_rst_n) begin
                mac_q[i].delete();
                we_q[i].delete();
                done_q[i].delete();
                last_g[i]  = 1'b1;
                next_ok[i] = cyc + 1;
                busy_to[i] = 0;
            end else if (cyc >= next_ok[i] && m_r != 2'b00) begin
                m_g = (m_r == 2'b11) ? ~last_g[i] : m_r[1];
                last_g[i] = m_g;
                m_p    = cols_of(i) + lat_of(i) + 1;
                m_base = cyc + 1;
                for (int r = 0; r < rows_of(i); r++) begin
                    for (int c = 0; c < cols_of(i); c++) begin
                        m_e = '{cyc: m_base + r*m_p + c, grant: m_g, row: 2'(r),
                                col: 2'(c), clr: (c == 0), done: 2'b00};
                        mac_q[i].push_back(m_e);
                    end
                    m_e = '{cyc: m_base + r*m_p + cols_of(i) + lat_of(i), grant: m_g,
                            row: 2'(r), col: 2'b00, clr: 1'b0, done: 2'b00};
                    we_q[i].push_back(m_e);
                end
                m_e = '{cyc: m_base + rows_of(i)*m_p, grant: m_g, row: 2'b00, col: 2'b00,
                        clr: 1'b0, done: (m_g ? 2'b10 : 2'b01)};
                done_q[i].push_back(m_e);
                busy_from[i] = m_base;
                busy_to[i]   = m_base + rows_of(i)*m_p;
                exp_g[i]     = m_g;
                next_ok[i]   = cyc + rows_of(i)*m_p + 2;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the queue heads.
    evt_t me;
    bit   pend, busy_exp;
    always @(negedge ap_clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                pend = (mac_q[i].size() > 0) && (mac_q[i][0].cyc <= cyc);
                if (pend || mac_o[i]) begin
                    chk("mac_en", mac_o[i] == pend, int'(mac_o[i]), int'(pend));
                    if (pend) begin
                        me = mac_q[i].pop_front();
                        if (mac_o[i])
                            chk("mac_fields",
                                {gnt_o[i], row_o[i], col_o[i], clr_o[i]} == {me.grant, me.row, me.col, me.clr},
                                int'({gnt_o[i], row_o[i], col_o[i], clr_o[i]}),
                                int'({me.grant, me.row, me.col, me.clr}));
                    end
                end
                if (clr_o[i] && !mac_o[i])
                    chk("clr_without_mac", clr_o[i] == 1'b0, int'(clr_o[i]), 0);

                pend = (we_q[i].size() > 0) && (we_q[i][0].cyc <= cyc);
                if (pend || we_o[i]) begin
                    chk("res_we", we_o[i] == pend, int'(we_o[i]), int'(pend));
                    if (pend) begin
                        me = we_q[i].pop_front();
                        if (we_o[i])
                            chk("res_row", rrow_o[i] == me.row, int'(rrow_o[i]), int'(me.row));
                    end
                end

                pend = (done_q[i].size() > 0) && (done_q[i][0].cyc <= cyc);
                if (pend || done_o[i] != 2'b00) begin
                    if (pend) begin
                        me = done_q[i].pop_front();
                        chk("done", done_o[i] == me.done, int'(done_o[i]), int'(me.done));
                        n_done[i]++;
                    end else begin
                        chk("done_spurious", done_o[i] == 2'b00, int'(done_o[i]), 0);
                    end
                end

                busy_exp = (cyc >= busy_from[i]) && (cyc <= busy_to[i]);
                chk("busy", busy_o[i] == busy_exp, int'(busy_o[i]), int'(busy_exp));
                if (busy_exp)
                    chk("grant_id", gnt_o[i] == exp_g[i], int'(gnt_o[i]), int'(exp_g[i]));
            end
        end
    end

    task automatic wait_done(input int b, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge ap_clk);
            if (done_o[0][b]) seen = 1'b1;
        end
        chk("wait_done", seen == 1'b1, int'(seen), 1);
    endtask

    task automatic wait_mac_fall(input int maxc);
        bit hi, fell;
        hi = 1'b0;
        fell = 1'b0;
        for (int k = 0; k < maxc && !fell; k++) begin
            @(negedge ap_clk);
            if (mac_o[0]) hi = 1'b1;
            else if (hi) fell = 1'b1;
        end
        chk("wait_mac_fall", fell == 1'b1, int'(fell), 1);
    endtask

    task automatic chk_reset_vals(input int i);
        chk("rst_busy",  busy_o[i] == 1'b0, int'(busy_o[i]), 0);
        chk("rst_mac",   {mac_o[i], clr_o[i], we_o[i]} == 3'b000, int'({mac_o[i], clr_o[i], we_o[i]}), 0);
        chk("rst_done",  done_o[i] == 2'b00, int'(done_o[i]), 0);
        chk("rst_grant", gnt_o[i] == 1'b0, int'(gnt_o[i]), 0);
        chk("rst_idx",   {row_o[i], col_o[i], rrow_o[i]} == 6'd0, int'({row_o[i], col_o[i], rrow_o[i]}), 0);
    endtask

    // Variant stimulus: one held request, then random request patterns.
    initial begin
        req1 = 2'b00;
        wait (var_run);
        @(negedge ap_clk);
        req1 = 2'b01;
        repeat (20) @(negedge ap_clk);
        while (var_run) begin
            req1 = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 30)) @(negedge ap_clk);
        end
        req1 = 2'b00;
    end

    initial begin
        ap_rst_n = 1'b0;
        req0     = 2'b00;
        repeat (3) @(negedge ap_clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        ap_rst_n = 1'b1;
        var_run  = 1'b1;

        // Single held predictor request.
        req0 = 2'b01;
        wait_done(0, 40);
        req0 = 2'b00;
        repeat (3) @(negedge ap_clk);

        // Simultaneous requests straight out of reset: 0, 1, then 0 again.
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        req0 = 2'b11;
        wait_done(0, 40);
        wait_done(1, 40);
        wait_done(0, 40);
        req0 = 2'b00;
        repeat (3) @(negedge ap_clk);

        // Corrector request arriving mid-job.
        req0 = 2'b01;
        repeat (6) @(negedge ap_clk);
        req0 = 2'b11;
        wait_done(0, 40);
        req0 = 2'b10;
        wait_done(1, 40);
        req0 = 2'b00;
        repeat (3) @(negedge ap_clk);

        // Early deassert still runs the full job.
        req0 = 2'b01;
        repeat (2) @(negedge ap_clk);
        req0 = 2'b00;
        wait_done(0, 40);
        repeat (3) @(negedge ap_clk);

        // Reset while draining the first row; no done for the aborted job.
        req0 = 2'b01;
        wait_mac_fall(20);
        ap_rst_n = 1'b0;
        req0 = 2'b00;
        @(negedge ap_clk);
        chk_reset_vals(0);
        ap_rst_n = 1'b1;
        repeat (25) @(negedge ap_clk);
        req0 = 2'b01;
        wait_done(0, 40);
        req0 = 2'b00;

        // Random request patterns, including early drops.
        repeat (12) begin
            req0 = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 25)) @(negedge ap_clk);
        end
        req0 = 2'b00;
        var_run = 1'b0;
        repeat (80) @(negedge ap_clk);

        for (int i = 0; i < 2; i++) begin
            chk("mac_left",  mac_q[i].size() == 0,  mac_q[i].size(),  0);
            chk("we_left",   we_q[i].size() == 0,   we_q[i].size(),   0);
            chk("done_left", done_q[i].size() == 0, done_q[i].size(), 0);
            chk("jobs_seen", n_done[i] >= 1, n_done[i], 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
